// File: rtl/vector_alu_if.sv
// Control and RAM-port bundle for vector_alu; master is the sequencer/RAM side,
// slave is the ALU itself.
interface vector_alu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int ACC_WIDTH  = 72
);
  logic                  start;
  logic [1:0]            op;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [ADDR_WIDTH-1:0] x_addr;
  logic [DATA_WIDTH-1:0] x_dout;
  logic [ADDR_WIDTH-1:0] y_addr;
  logic [DATA_WIDTH-1:0] y_dout;
  logic [ADDR_WIDTH-1:0] z_addr;
  logic [DATA_WIDTH-1:0] z_din;
  logic                  z_wr_en;
  logic [ACC_WIDTH-1:0]  acc_out;

  modport master (
    output start, op, length, x_dout, y_dout,
    input  busy, done, overflow, x_addr, y_addr, z_addr, z_din, z_wr_en, acc_out
  );

  modport slave (
    input  start, op, length, x_dout, y_dout,
    output busy, done, overflow, x_addr, y_addr, z_addr, z_din, z_wr_en, acc_out
  );
endinterface

// File: rtl/vector_alu.sv
// Streaming vector ALU (ADD/SUB/MUL into z RAM, DOT into accumulator), one element per clock.
// start-to-done is length+2 cycles (1 for length=0); no backpressure, the RAMs are always ready.
module vector_alu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int ACC_WIDTH  = 72,
  parameter bit SATURATE   = 1'b1
) (
  input logic         clock,
  input logic         reset,
  vector_alu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_DOT = 2'd3;
  localparam logic [ADDR_WIDTH:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic signed [2*DATA_WIDTH-1:0] S_MAX =
    {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [2*DATA_WIDTH-1:0] S_MIN =
    {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  state_t                state, state_nxt;
  logic [1:0]            op_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   rd_idx;
  logic [ADDR_WIDTH:0]   last_idx;
  logic                  wr_vld;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [ACC_WIDTH-1:0]  acc;
  logic                  ovf;

  logic [DATA_WIDTH:0]             x_ext, y_ext, sum_w;
  logic signed [2*DATA_WIDTH-1:0]  x_wide, y_wide, prod, wide;
  logic signed [ACC_WIDTH-1:0]     prod_ext;
  logic                            elem_ovf;
  logic [DATA_WIDTH-1:0]           res;

  // Terminal compare at ADDR_WIDTH+1 bits so a full 2^ADDR_WIDTH run cannot wrap early.
  assign last_idx = len_q - LEN_ONE;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (bus.length == '0) ? FIN : RUN;
      RUN:     if (rd_idx == last_idx) state_nxt = DRAIN;
      DRAIN:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    x_ext    = {bus.x_dout[DATA_WIDTH-1], bus.x_dout};
    y_ext    = {bus.y_dout[DATA_WIDTH-1], bus.y_dout};
    sum_w    = (op_q == OP_SUB) ? (x_ext - y_ext) : (x_ext + y_ext);
    x_wide   = {{DATA_WIDTH{bus.x_dout[DATA_WIDTH-1]}}, bus.x_dout};
    y_wide   = {{DATA_WIDTH{bus.y_dout[DATA_WIDTH-1]}}, bus.y_dout};
    prod     = x_wide * y_wide;
    wide     = op_q[1] ? prod : {{(DATA_WIDTH-1){sum_w[DATA_WIDTH]}}, sum_w};
    elem_ovf = (wide > S_MAX) || (wide < S_MIN);
    if (elem_ovf && SATURATE)
      res = wide[2*DATA_WIDTH-1] ? S_MIN[DATA_WIDTH-1:0] : S_MAX[DATA_WIDTH-1:0];
    else
      res = wide[DATA_WIDTH-1:0];
  end

  assign prod_ext = ACC_WIDTH'(prod);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      len_q  <= '0;
      rd_idx <= '0;
      wr_vld <= 1'b0;
      wr_idx <= '0;
      acc    <= '0;
      ovf    <= 1'b0;
    end else begin
      wr_vld <= (state == RUN);
      wr_idx <= rd_idx[ADDR_WIDTH-1:0];
      if (state == IDLE && bus.start) begin
        op_q   <= bus.op;
        len_q  <= bus.length;
        rd_idx <= '0;
        acc    <= '0;
        ovf    <= 1'b0;
      end else if (state == RUN) begin
        rd_idx <= rd_idx + LEN_ONE;
      end
      if (wr_vld) begin
        if (op_q == OP_DOT) acc <= acc + prod_ext;
        else if (elem_ovf)  ovf <= 1'b1;
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == FIN);
  assign bus.overflow = ovf;
  assign bus.acc_out  = acc;
  assign bus.x_addr   = (state == RUN) ? rd_idx[ADDR_WIDTH-1:0] : '0;
  assign bus.y_addr   = (state == RUN) ? rd_idx[ADDR_WIDTH-1:0] : '0;
  assign bus.z_addr   = wr_vld ? wr_idx : '0;
  assign bus.z_din    = wr_vld ? res : '0;
  assign bus.z_wr_en  = wr_vld && (op_q != OP_DOT);
endmodule

// File: tb/tb_vector_alu.sv
// Bench for vector_alu: a saturating and a wrapping instance run side by side on the same
// RAM contents and stimulus, checked against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_vector_alu;
  localparam int DW   = 32;
  localparam int AW   = 10;
  localparam int ACCW = 72;
  localparam int N    = 1 << AW;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  localparam logic [DW-1:0] SENT = 32'hDEAD_BEEF;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  vector_alu_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW)) bs ();
  vector_alu_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW)) bw ();

  vector_alu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW), .SATURATE(1'b1))
    dut_sat (.clock(clock), .reset(reset), .bus(bs));
  vector_alu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW), .SATURATE(1'b0))
    dut_wrap (.clock(clock), .reset(reset), .bus(bw));

  // index 0 = saturating instance, 1 = wrapping instance
  logic            busy_o [2];
  logic            done_o [2];
  logic            ovf_o  [2];
  logic            wr_o   [2];
  logic [AW-1:0]   xa_o   [2];
  logic [AW-1:0]   ya_o   [2];
  logic [AW-1:0]   za_o   [2];
  logic [DW-1:0]   zd_o   [2];
  logic [ACCW-1:0] acc_o  [2];
  assign busy_o[0] = bs.busy;     assign busy_o[1] = bw.busy;
  assign done_o[0] = bs.done;     assign done_o[1] = bw.done;
  assign ovf_o[0]  = bs.overflow; assign ovf_o[1]  = bw.overflow;
  assign wr_o[0]   = bs.z_wr_en;  assign wr_o[1]   = bw.z_wr_en;
  assign xa_o[0]   = bs.x_addr;   assign xa_o[1]   = bw.x_addr;
  assign ya_o[0]   = bs.y_addr;   assign ya_o[1]   = bw.y_addr;
  assign za_o[0]   = bs.z_addr;   assign za_o[1]   = bw.z_addr;
  assign zd_o[0]   = bs.z_din;    assign zd_o[1]   = bw.z_din;
  assign acc_o[0]  = bs.acc_out;  assign acc_o[1]  = bw.acc_out;

  logic [DW-1:0] x_mem [N];
  logic [DW-1:0] y_mem [N];
  logic [DW-1:0] z_mem [2][N];
  bit            clr_z;

  always @(posedge clock) begin
    bs.x_dout <= x_mem[bs.x_addr];
    bs.y_dout <= y_mem[bs.y_addr];
    bw.x_dout <= x_mem[bw.x_addr];
    bw.y_dout <= y_mem[bw.y_addr];
    if (clr_z) begin
      for (int k = 0; k < N; k++) begin
        z_mem[0][k] <= SENT;
        z_mem[1][k] <= SENT;
      end
    end else begin
      if (bs.z_wr_en) z_mem[0][bs.z_addr] <= bs.z_din;
      if (bw.z_wr_en) z_mem[1][bw.z_addr] <= bw.z_din;
    end
  end

  // expected results
  logic [DW-1:0]          exp_z [2][N];
  bit                     exp_ovf [2];
  logic signed [ACCW-1:0] exp_acc;

  // observations of the last run_op
  int              done_cyc [2], done_cnt [2], wr_cnt [2], wr_first [2], wr_last [2];
  int              wr_bad [2], rd_bad [2], busy_cnt [2];
  logic            idle_busy [2], ovf_d [2];
  logic [ACCW-1:0] acc_d [2];

  task automatic drive(input logic s, input logic [1:0] o, input logic [AW:0] l);
    bs.start = s; bs.op = o; bs.length = l;
    bw.start = s; bw.op = o; bw.length = l;
  endtask

  task automatic set_start(input logic s);
    bs.start = s;
    bw.start = s;
  endtask

  task automatic clear_z;
    clr_z = 1'b1;
    @(posedge clock);
    #1 clr_z = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_elem();
    logic [DW-1:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      default: begin v = $urandom_range(0, 2000); v = v - 32'd1000; end
    endcase
    return v;
  endfunction

  task automatic fill_random(input int len);
    for (int k = 0; k < len; k++) begin
      x_mem[k] = rnd_elem();
      y_mem[k] = rnd_elem();
    end
  endtask

  // Reference: exact integer result, then clamp or truncate to DW bits.
  function automatic logic [DW:0] model_elem(input logic [1:0] o, input logic [DW-1:0] x,
                                             input logic [DW-1:0] y, input bit sat);
    longint a, b, r, lim;
    logic [DW-1:0] z;
    bit ov;
    a = longint'($signed(x));
    b = longint'($signed(y));
    case (o)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      default: r = a * b;
    endcase
    ov  = (r > SMAX) || (r < SMIN);
    lim = (r < 0) ? SMIN : SMAX;
    z   = (ov && sat) ? lim[DW-1:0] : r[DW-1:0];
    return {ov, z};
  endfunction

  task automatic build_expected(input logic [1:0] o, input int len);
    logic [DW:0] m;
    longint p;
    exp_acc = '0;
    for (int i = 0; i < 2; i++) begin
      exp_ovf[i] = 1'b0;
      for (int k = 0; k < N; k++) exp_z[i][k] = SENT;
    end
    for (int k = 0; k < len; k++) begin
      if (o == 2'd3) begin
        p = longint'($signed(x_mem[k])) * longint'($signed(y_mem[k]));
        exp_acc = exp_acc + ACCW'(p);
      end else begin
        for (int i = 0; i < 2; i++) begin
          m = model_elem(o, x_mem[k], y_mem[k], i == 0);
          exp_z[i][k] = m[DW-1:0];
          if (m[DW]) exp_ovf[i] = 1'b1;
        end
      end
    end
  endtask

  // Starts an operation (start is also raised in the done cycle, which must be ignored)
  // and records what both instances do until the cycle after done or a cycle budget.
  task automatic run_op(input logic [1:0] o, input int len, input bit poke);
    int exp_done, c, ra;
    bit fin;
    exp_done = (len == 0) ? 1 : len + 2;
    for (int i = 0; i < 2; i++) begin
      done_cyc[i] = -1; done_cnt[i] = 0; wr_cnt[i] = 0; wr_first[i] = -1; wr_last[i] = -1;
      wr_bad[i] = 0; rd_bad[i] = 0; busy_cnt[i] = 0; idle_busy[i] = 1'b1;
      ovf_d[i] = 1'b0; acc_d[i] = '0;
    end
    drive(1'b1, o, len[AW:0]);
    @(posedge clock);
    #1 set_start((exp_done == 1) ? 1'b1 : (poke ? 1'($urandom_range(0, 1)) : 1'b0));
    c = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clock);
      c++;
      ra = (c >= 1 && c <= len) ? c - 1 : 0;
      for (int i = 0; i < 2; i++) begin
        if (busy_o[i]) busy_cnt[i]++;
        if (xa_o[i] != ra[AW-1:0] || ya_o[i] != ra[AW-1:0]) rd_bad[i]++;
        if (wr_o[i]) begin
          wr_cnt[i]++;
          if (wr_first[i] < 0) wr_first[i] = c;
          wr_last[i] = c;
          if (int'(za_o[i]) != c - 2) wr_bad[i]++;
        end
        if (done_o[i]) begin
          done_cnt[i]++; done_cyc[i] = c; ovf_d[i] = ovf_o[i]; acc_d[i] = acc_o[i];
        end
        if (done_cyc[i] >= 0 && c == done_cyc[i] + 1) idle_busy[i] = busy_o[i];
      end
      if (c + 1 == exp_done)        set_start(1'b1);
      else if (poke && c + 1 < exp_done) set_start(1'($urandom_range(0, 1)));
      else                          set_start(1'b0);
      if ((done_cyc[0] >= 0 && done_cyc[1] >= 0 && c > done_cyc[0] && c > done_cyc[1]) ||
          c >= exp_done + 8)
        fin = 1'b1;
    end
    set_start(1'b0);
  endtask

  task automatic test_reset;
    drive(1'b0, 2'd0, '0);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({busy_o[i], done_o[i], ovf_o[i], wr_o[i], xa_o[i], ya_o[i], za_o[i], zd_o[i], acc_o[i]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs[%0d] got %h want 0", i,
                 {busy_o[i], done_o[i], ovf_o[i], wr_o[i], xa_o[i], ya_o[i], za_o[i], zd_o[i], acc_o[i]});
      end
    end
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({busy_o[i], done_o[i], wr_o[i], xa_o[i], za_o[i], zd_o[i], acc_o[i]} !== '0) begin
        errors++;
        $display("FAIL idle_after_reset[%0d] got %h want 0", i,
                 {busy_o[i], done_o[i], wr_o[i], xa_o[i], za_o[i], zd_o[i], acc_o[i]});
      end
    end
  endtask

  task automatic test_add;
    logic [DW-1:0] want [4];
    want = '{32'd11, 32'd22, 32'd33, 32'd44};
    for (int k = 0; k < 4; k++) begin
      x_mem[k] = DW'(k + 1);
      y_mem[k] = DW'(10 * (k + 1));
    end
    clear_z;
    run_op(2'd0, 4, 1'b0);
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (z_mem[i][k] !== want[k]) begin
          errors++;
          $display("FAIL add_z[%0d][%0d] got %h want %h", i, k, z_mem[i][k], want[k]);
        end
      end
      checks++;
      if (wr_first[i] != 2 || wr_last[i] != 5 || wr_cnt[i] != 4 || wr_bad[i] != 0 ||
          done_cyc[i] != 6 || done_cnt[i] != 1 || rd_bad[i] != 0) begin
        errors++;
        $display("FAIL add_timing[%0d] got first=%0d last=%0d cnt=%0d badaddr=%0d done=%0d/%0d rdbad=%0d want 2 5 4 0 6/1 0",
                 i, wr_first[i], wr_last[i], wr_cnt[i], wr_bad[i], done_cyc[i], done_cnt[i], rd_bad[i]);
      end
      checks++;
      if (ovf_d[i] !== 1'b0 || acc_d[i] !== '0 || idle_busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL add_flags[%0d] got ovf=%b acc=%h idle_busy=%b want 0 0 0", i, ovf_d[i], acc_d[i], idle_busy[i]);
      end
    end
  endtask

  task automatic test_sub_overflow;
    logic [DW-1:0] want [2];
    want = '{32'h8000_0000, 32'h7FFF_FFFF};
    x_mem[0] = 32'h8000_0000;
    y_mem[0] = 32'd1;
    clear_z;
    run_op(2'd1, 1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (z_mem[i][0] !== want[i] || ovf_d[i] !== 1'b1) begin
        errors++;
        $display("FAIL sub_ovf[%0d] got z=%h ovf=%b want z=%h ovf=1", i, z_mem[i][0], ovf_d[i], want[i]);
      end
      checks++;
      if (done_cyc[i] != 3 || wr_cnt[i] != 1 || wr_first[i] != 2) begin
        errors++;
        $display("FAIL sub_timing[%0d] got done=%0d wr=%0d first=%0d want 3 1 2", i, done_cyc[i], wr_cnt[i], wr_first[i]);
      end
    end
  endtask

  task automatic test_dot;
    logic signed [ACCW-1:0] want;
    want = -72'sd36;
    x_mem[0] = 32'd2;  x_mem[1] = -32'sd3; x_mem[2] = 32'd4;
    y_mem[0] = 32'd5;  y_mem[1] = 32'd6;   y_mem[2] = -32'sd7;
    clear_z;
    run_op(2'd3, 3, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (acc_d[i] !== want || ovf_d[i] !== 1'b0) begin
        errors++;
        $display("FAIL dot_acc[%0d] got acc=%h ovf=%b want acc=%h ovf=0", i, acc_d[i], ovf_d[i], want);
      end
      checks++;
      if (wr_cnt[i] != 0 || done_cyc[i] != 5 || z_mem[i][0] !== SENT || z_mem[i][2] !== SENT) begin
        errors++;
        $display("FAIL dot_nowrite[%0d] got wr=%0d done=%0d z0=%h want 0 5 %h", i, wr_cnt[i], done_cyc[i], z_mem[i][0], SENT);
      end
    end
  endtask

  task automatic test_len0;
    run_op(2'd0, 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (done_cyc[i] != 1 || done_cnt[i] != 1 || busy_cnt[i] != 1 || wr_cnt[i] != 0 ||
          rd_bad[i] != 0 || idle_busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL len0[%0d] got done=%0d/%0d busy=%0d wr=%0d addr=%0d idle_busy=%b want 1/1 1 0 0 0",
                 i, done_cyc[i], done_cnt[i], busy_cnt[i], wr_cnt[i], rd_bad[i], idle_busy[i]);
      end
    end
  endtask

  task automatic test_random;
    int len, bad;
    logic [1:0] o;
    for (int n = 0; n < 8; n++) begin
      o   = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 48);
      fill_random(len);
      build_expected(o, len);
      clear_z;
      run_op(o, len, 1'b1);
      for (int i = 0; i < 2; i++) begin
        bad = 0;
        for (int k = 0; k < len + 4; k++) if (z_mem[i][k] !== exp_z[i][k]) bad++;
        checks++;
        if (bad != 0 || ovf_d[i] !== exp_ovf[i] || acc_d[i] !== exp_acc) begin
          errors++;
          $display("FAIL rand_result[%0d] op=%0d len=%0d got badz=%0d ovf=%b acc=%h want 0 %b %h",
                   i, o, len, bad, ovf_d[i], acc_d[i], exp_ovf[i], exp_acc);
        end
        checks++;
        if (done_cyc[i] != len + 2 || done_cnt[i] != 1 || wr_bad[i] != 0 || rd_bad[i] != 0 ||
            wr_cnt[i] != ((o == 2'd3) ? 0 : len) || idle_busy[i] !== 1'b0) begin
          errors++;
          $display("FAIL rand_timing[%0d] op=%0d len=%0d got done=%0d/%0d wr=%0d wrbad=%0d rdbad=%0d idle_busy=%b",
                   i, o, len, done_cyc[i], done_cnt[i], wr_cnt[i], wr_bad[i], rd_bad[i], idle_busy[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int bad;
    for (int n = 0; n < 2; n++) begin
      fill_random(5 - 2 * n);
      build_expected(2'(n), 5 - 2 * n);
      run_op(2'(n), 5 - 2 * n, 1'b0);
      for (int i = 0; i < 2; i++) begin
        bad = 0;
        for (int k = 0; k < 5 - 2 * n; k++) if (z_mem[i][k] !== exp_z[i][k]) bad++;
        checks++;
        if (bad != 0 || done_cyc[i] != 7 - 2 * n || idle_busy[i] !== 1'b0 || ovf_d[i] !== exp_ovf[i]) begin
          errors++;
          $display("FAIL b2b[%0d] run=%0d got badz=%0d done=%0d idle_busy=%b ovf=%b want 0 %0d 0 %b",
                   i, n, bad, done_cyc[i], idle_busy[i], ovf_d[i], 7 - 2 * n, exp_ovf[i]);
        end
      end
    end
  endtask

  task automatic test_mul_full;
    int bad;
    fill_random(N);
    build_expected(2'd2, N);
    clear_z;
    run_op(2'd2, N, 1'b1);
    for (int i = 0; i < 2; i++) begin
      bad = 0;
      for (int k = 0; k < N; k++) if (z_mem[i][k] !== exp_z[i][k]) bad++;
      checks++;
      if (bad != 0 || ovf_d[i] !== exp_ovf[i]) begin
        errors++;
        $display("FAIL mul_full_data[%0d] got badz=%0d ovf=%b want 0 %b", i, bad, ovf_d[i], exp_ovf[i]);
      end
      checks++;
      if (wr_cnt[i] != N || wr_first[i] != 2 || wr_last[i] != N + 1 || wr_bad[i] != 0 ||
          done_cyc[i] != N + 2 || done_cnt[i] != 1 || idle_busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL mul_full_timing[%0d] got wr=%0d first=%0d last=%0d wrbad=%0d done=%0d/%0d idle_busy=%b want %0d 2 %0d 0 %0d/1 0",
                 i, wr_cnt[i], wr_first[i], wr_last[i], wr_bad[i], done_cyc[i], done_cnt[i], idle_busy[i], N, N + 1, N + 2);
      end
    end
  endtask

  task automatic test_reset_midop;
    int wr_after, done_after, bad;
    fill_random(16);
    build_expected(2'd0, 16);
    clear_z;
    drive(1'b1, 2'd0, 11'd16);
    @(posedge clock);
    #1 set_start(1'b0);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({busy_o[i], done_o[i], ovf_o[i], wr_o[i], xa_o[i], ya_o[i], za_o[i], zd_o[i], acc_o[i]} !== '0) begin
        errors++;
        $display("FAIL midop_reset_outputs[%0d] got %h want 0", i,
                 {busy_o[i], done_o[i], ovf_o[i], wr_o[i], xa_o[i], ya_o[i], za_o[i], zd_o[i], acc_o[i]});
      end
    end
    wr_after = 0;
    done_after = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (c == 1) reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (wr_o[i]) wr_after++;
        if (done_o[i]) done_after++;
      end
    end
    checks++;
    if (wr_after != 0 || done_after != 0) begin
      errors++;
      $display("FAIL midop_abort got writes=%0d dones=%0d want 0 0", wr_after, done_after);
    end
    for (int i = 0; i < 2; i++) begin
      bad = 0;
      for (int k = 0; k < 16; k++)
        if (z_mem[i][k] !== ((k < 3) ? exp_z[i][k] : SENT)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL midop_partial_z[%0d] got %0d wrong entries want 0", i, bad);
      end
    end
    fill_random(6);
    build_expected(2'd1, 6);
    clear_z;
    run_op(2'd1, 6, 1'b0);
    for (int i = 0; i < 2; i++) begin
      bad = 0;
      for (int k = 0; k < 10; k++) if (z_mem[i][k] !== exp_z[i][k]) bad++;
      checks++;
      if (bad != 0 || done_cyc[i] != 8 || ovf_d[i] !== exp_ovf[i]) begin
        errors++;
        $display("FAIL after_reset_run[%0d] got badz=%0d done=%0d ovf=%b want 0 8 %b", i, bad, done_cyc[i], ovf_d[i], exp_ovf[i]);
      end
    end
  endtask

  initial begin
    clr_z = 1'b0;
    for (int k = 0; k < N; k++) begin
      x_mem[k] = '0;
      y_mem[k] = '0;
    end
    test_reset;
    test_add;
    test_sub_overflow;
    test_dot;
    test_len0;
    test_back_to_back;
    test_random;
    test_mul_full;
    test_reset_midop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
